seq_mac_responder: RTL and testbench
====================================

Name: seq_mac_responder

Overview:
- Responder end of the start/done operand interface: takes 9-bit X, Y, Z from an initiator and computes result = X*Y + Z.
- The initiator is a bench or controller that raises start, holds it an arbitrary number of cycles, then waits for done.
- Multiplies over several cycles with a shift-add datapath that consumes P bits of Y per cycle.
- Sits in CA3 as the compute core that a top-level controller or testbench drives.

Parameters:
- P, 4, bits of Y consumed per iteration; legal range 1..9; N = ceil(9/P) iterations (P=4 gives N=3).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level request; an operation launches only on its 0->1 transition
- X  input  9  unsigned multiplicand
- Y  input  9  unsigned multiplier
- Z  input  9  unsigned addend
- busy  output  1  high while iterations are in progress
- done  output  1  single-cycle completion pulse
- result  output  18  X*Y+Z, unsigned; max 511*511+511 = 261632 fits in 18 bits

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, result=0, accumulator=0, iteration counter=0, start_q=0. Reset mid-operation aborts it with no done.
- start_q is a registered copy of start. A launch occurs at an edge where start=1 and start_q=0.
  - Because start_q resets to 0, a start held high across reset release launches at the first clock edge after release.
- States:
  - IDLE: on launch, latch X, Y (zero-extended to N*P bits) and Z; set acc=Z, cnt=0, busy=1; go to RUN. Otherwise stay.
  - RUN: each edge, acc <= acc + ((Xl * Yl[P*cnt +: P]) << (P*cnt)) and cnt <= cnt+1. On the edge with cnt==N-1, go to DONE with result <= the final sum, busy=0, done=1.
  - DONE: lasts one cycle; done=1. On the next edge done<=0. If a launch is detected on that edge, go to RUN as from IDLE; otherwise go to IDLE.
- Latency: done rises exactly N edges after the launch edge (3 for P=4, 9 for P=1).
- busy is high for the N cycles before done.
- start activity during RUN is ignored. start held high continuously causes exactly one operation; a new operation needs start to go low for at least one sampled edge.
- X, Y, Z changes after the launch edge have no effect on the running operation.
- result holds its value from the done cycle until the next done or reset. It does not change while busy.
- Widths:
  - Per-iteration partial product is (9+P) bits.
  - The accumulator is 18 bits wide and never overflows for legal inputs.
  - The top chunk of Y is zero-padded when P does not divide 9.

Test Plan:
1. P=4. X=16, Y=0, Z=0; start=1 from time 0 (rst_n released after 2 cycles), held 10 cycles -> exactly one done pulse, 3 edges after the first post-reset edge; result=0; no second pulse while start stays high.
2. P=4. X=511, Y=511, Z=511; single launch -> result=261632; busy high 3 cycles; done high 1 cycle.
3. P=4. Back-to-back: X=3, Y=5, Z=7, then start low for 1 cycle after done, then X=10, Y=10, Z=1 -> first result=22, second result=101. result holds 22 until the second done.
4. P=4. Launch X=100, Y=200, Z=0; assert rst_n=0 during the second RUN cycle with start held high; release -> busy/done/result go 0 immediately, with no done pulse for the aborted operation. A new operation launches at the first edge after release and ends with result=20000.
5. P=4. Change X/Y/Z to 0 on the cycle after launch with X=7, Y=9, Z=2 -> result=65, unaffected.
6. P=1 build. X=2, Y=256, Z=0 -> done 9 edges after launch; result=512.

Source files
------------

// File: rtl/seq_mac_responder.sv
// seq_mac_responder: multi-cycle multiply-accumulate responder.
// Computes result = X*Y + Z with a shift-add datapath that consumes P bits
// of the latched multiplier per cycle, launched on a rising edge of start.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for a start rising edge; result holds the last value
// S_RUN  | iterating over P-bit chunks of Y, busy high
// S_DONE | one-cycle done pulse; a fresh launch here goes straight to RUN

module seq_mac_responder #(
    parameter int P = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [8:0]  X,
    input  logic [8:0]  Y,
    input  logic [8:0]  Z,
    output logic        busy,
    output logic        done,
    output logic [17:0] result
);

    localparam int N  = (9 + P - 1) / P;
    localparam int YW = N * P;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            start_q, start_d;
    logic [8:0]      xl_q, xl_d;
    logic [YW-1:0]   yl_q, yl_d;
    logic [17:0]     acc_q, acc_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [17:0]     result_q, result_d;

    logic            launch;
    int              sh;
    logic [P-1:0]    chunk;
    logic [8+P:0]    pp;
    logic [17:0]     addend;
    logic [17:0]     acc_sum;

    assign launch = start & ~start_q;

    // Partial product for the current chunk, aligned to its bit position.
    always_comb begin
        sh      = int'(cnt_q) * P;
        chunk   = yl_q[sh +: P];
        pp      = {{P{1'b0}}, xl_q} * {9'd0, chunk};
        addend  = 18'(pp) << sh;
        acc_sum = acc_q + addend;
    end

    // Next-state and registered-output computation for the sequencer.
    always_comb begin
        state_d  = state_q;
        start_d  = start;
        xl_d     = xl_q;
        yl_d     = yl_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (launch) begin
                    state_d = S_RUN;
                    xl_d    = X;
                    yl_d    = YW'(Y);
                    acc_d   = {9'd0, Z};
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(N - 1)) begin
                    state_d  = S_DONE;
                    result_d = acc_sum;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            xl_q     <= '0;
            yl_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            xl_q     <= xl_d;
            yl_q     <= yl_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_mac_responder.sv
// Directed bench for seq_mac_responder: a P=4 instance and a P=1 instance.
module tb_seq_mac_responder;

    logic        clk;
    logic        rst_n;
    logic        start4, start1;
    logic [8:0]  X4, Y4, Z4, X1, Y1, Z1;
    logic        busy4, done4, busy1, done1;
    logic [17:0] result4, result1;

    int n_cmp;
    int n_err;

    seq_mac_responder #(.P(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .X(X4), .Y(Y4), .Z(Z4),
        .busy(busy4), .done(done4), .result(result4)
    );

    seq_mac_responder #(.P(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .X(X1), .Y(Y1), .Z(Z1),
        .busy(busy1), .done(done1), .result(result1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives operands and start=1, then follows the
    // selected instance until done, checking latency, busy span, hold of
    // result while busy, and the final result. Returns at the done negedge.
    task automatic op(input string tag, input bit d1,
                      input logic [8:0] x, input logic [8:0] y, input logic [8:0] z,
                      input int exp_lat, input logic [17:0] exp_res,
                      input logic [17:0] hold_res, input bit drop, input bit chg);
        int lat;
        int busy_cnt;
        lat = -1;
        busy_cnt = 0;
        if (d1) begin X1 = x; Y1 = y; Z1 = z; start1 = 1'b1; end
        else    begin X4 = x; Y4 = y; Z4 = z; start4 = 1'b1; end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (d1 ? done1 : done4) begin
                lat = k - 1;
                break;
            end
            if (d1 ? busy1 : busy4) busy_cnt++;
            chk({tag, " hold"}, 32'(d1 ? result1 : result4), 32'(hold_res));
            if (k == 1 && drop) begin
                if (d1) start1 = 1'b0; else start4 = 1'b0;
            end
            if (k == 1 && chg) begin
                if (d1) begin X1 = '0; Y1 = '0; Z1 = '0; end
                else    begin X4 = '0; Y4 = '0; Z4 = '0; end
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        chk({tag, " busy_at_done"}, 32'(d1 ? busy1 : busy4), 32'd0);
        chk({tag, " result"}, 32'(d1 ? result1 : result4), 32'(exp_res));
    endtask

    initial begin
        int pulses;
        int first_k;
        n_cmp = 0;
        n_err = 0;

        // Test 1: start high through reset release, one launch only.
        rst_n = 1'b0;
        start4 = 1'b1; X4 = 9'd16; Y4 = 9'd0; Z4 = 9'd0;
        start1 = 1'b0; X1 = 9'd0;  Y1 = 9'd0; Z1 = 9'd0;
        #3;
        chk("reset busy", 32'(busy4), 32'd0);
        chk("reset done", 32'(done4), 32'd0);
        chk("reset result", 32'(result4), 32'd0);
        chk("reset busy p1", 32'(busy1), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        first_k = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done4) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        chk("t1 pulses", 32'(pulses), 32'd1);
        chk("t1 latency", 32'(first_k - 1), 32'd3);
        chk("t1 result", 32'(result4), 32'd0);
        chk("t1 busy idle", 32'(busy4), 32'd0);
        start4 = 1'b0;
        @(negedge clk);

        // Test 2: full-scale operands.
        op("t2", 1'b0, 9'd511, 9'd511, 9'd511, 3, 18'd261632, 18'd0, 1'b0, 1'b0);
        start4 = 1'b0;
        @(negedge clk);
        chk("t2 done single", 32'(done4), 32'd0);
        chk("t2 result held", 32'(result4), 32'd261632);

        // Test 3: two operations with start low for one edge between them.
        op("t3a", 1'b0, 9'd3, 9'd5, 9'd7, 3, 18'd22, 18'd261632, 1'b0, 1'b0);
        start4 = 1'b0;
        @(negedge clk);
        chk("t3 gap result", 32'(result4), 32'd22);
        chk("t3 gap busy", 32'(busy4), 32'd0);
        op("t3b", 1'b0, 9'd10, 9'd10, 9'd1, 3, 18'd101, 18'd22, 1'b0, 1'b0);
        start4 = 1'b0;
        @(negedge clk);

        // Launch on the edge leaving DONE (start dropped during RUN).
        op("t7a", 1'b0, 9'd2, 9'd3, 9'd4, 3, 18'd10, 18'd101, 1'b1, 1'b0);
        op("t7b", 1'b0, 9'd6, 9'd7, 9'd8, 3, 18'd50, 18'd10, 1'b0, 1'b0);
        start4 = 1'b0;
        @(negedge clk);

        // Test 5: operands change right after launch.
        op("t5", 1'b0, 9'd7, 9'd9, 9'd2, 3, 18'd65, 18'd50, 1'b0, 1'b1);
        start4 = 1'b0;
        @(negedge clk);

        // Test 4: reset during RUN, start held; relaunch after release.
        X4 = 9'd100; Y4 = 9'd200; Z4 = 9'd0; start4 = 1'b1;
        @(negedge clk);
        chk("t4 busy run", 32'(busy4), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4 abort busy", 32'(busy4), 32'd0);
        chk("t4 abort done", 32'(done4), 32'd0);
        chk("t4 abort result", 32'(result4), 32'd0);
        @(negedge clk);
        chk("t4 in reset done", 32'(done4), 32'd0);
        rst_n = 1'b1;
        op("t4", 1'b0, 9'd100, 9'd200, 9'd0, 3, 18'd20000, 18'd0, 1'b0, 1'b0);
        start4 = 1'b0;
        @(negedge clk);

        // Test 6: P=1 instance, nine iterations.
        op("t6a", 1'b1, 9'd2, 9'd256, 9'd0, 9, 18'd512, 18'd0, 1'b0, 1'b0);
        start1 = 1'b0;
        @(negedge clk);
        op("t6b", 1'b1, 9'd511, 9'd511, 9'd511, 9, 18'd261632, 18'd512, 1'b0, 1'b0);
        start1 = 1'b0;
        @(negedge clk);
        chk("t6 done single", 32'(done1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
